// File: rtl/multi_edge_filter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_edge_filter_if                                         |
// | Description : Bus bundle between raw control lines and multi_edge_filter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

interface multi_edge_filter_if #(
  parameter int NUM_CH = 2
);

  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] sticky_clr;
  logic [NUM_CH-1:0] filt_out;
  logic [NUM_CH-1:0] rising_edge;
  logic [NUM_CH-1:0] falling_edge;
  logic [NUM_CH-1:0] edge_sticky;

  modport master (
    output sig_in,
    output ch_en,
    output sticky_clr,
    input  filt_out,
    input  rising_edge,
    input  falling_edge,
    input  edge_sticky
  );

  modport slave (
    input  sig_in,
    input  ch_en,
    input  sticky_clr,
    output filt_out,
    output rising_edge,
    output falling_edge,
    output edge_sticky
  );

endinterface

`default_nettype wire

// File: rtl/multi_edge_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_edge_filter                                            |
// | Description : Per-channel synchroniser, glitch filter and edge reporting.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module multi_edge_filter #(
  parameter int   NUM_CH      = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  multi_edge_filter_if.slave bus
);

  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sticky_q, sticky_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], bus.sig_in[ch]};
      cnt_d    = cnt_q;
      filt_d   = filt_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      // A pulse in flight outranks a simultaneous clear so no edge is lost.
      sticky_d = (sticky_q & ~bus.sticky_clr[ch]) | rise_q | fall_q;

      if (!bus.ch_en[ch] || (s == filt_q)) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_d = s;
        rise_d = s;
        fall_d = ~s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
        cnt_q    <= '0;
        filt_q   <= RESET_LEVEL;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        cnt_q    <= cnt_d;
        filt_q   <= filt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        sticky_q <= sticky_d;
      end
    end

    assign bus.filt_out[ch]     = filt_q;
    assign bus.rising_edge[ch]  = rise_q;
    assign bus.falling_edge[ch] = fall_q;
    assign bus.edge_sticky[ch]  = sticky_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_edge_filter                                         |
// | Description : Self-checking bench: default build and FILTER_LEN=1 build.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_multi_edge_filter;

  localparam int SYNC_A = 2;
  localparam int FL_A   = 4;
  localparam int SYNC_B = 3;
  localparam int FL_B   = 1;

  logic       clk;
  logic       n_rst;
  logic [1:0] sig;
  logic [1:0] en;
  logic [1:0] clr;

  int checks = 0;
  int errors = 0;

  multi_edge_filter_if #(.NUM_CH(2)) bus_a ();
  multi_edge_filter_if #(.NUM_CH(2)) bus_b ();

  assign bus_a.sig_in     = sig;
  assign bus_a.ch_en      = en;
  assign bus_a.sticky_clr = clr;
  assign bus_b.sig_in     = sig;
  assign bus_b.ch_en      = en;
  assign bus_b.sticky_clr = clr;

  multi_edge_filter #(
    .NUM_CH(2), .SYNC_STAGES(SYNC_A), .FILTER_LEN(FL_A), .RESET_LEVEL(1'b1)
  ) u_dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a)
  );

  multi_edge_filter #(
    .NUM_CH(2), .SYNC_STAGES(SYNC_B), .FILTER_LEN(FL_B), .RESET_LEVEL(1'b1)
  ) u_dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: input history, a run of enabled cycles disagreeing with the
  // accepted level, and the reported events derived from those rules.
  typedef struct packed {
    logic [7:0] hist;
    logic [7:0] run;
    logic       filt;
    logic       rise;
    logic       fall;
    logic       sticky;
  } ch_t;

  ch_t m [2][2];

  function automatic ch_t model_step(ch_t cur, int sy, int fl, logic rst_n,
                                     logic din, logic ena, logic clear);
    ch_t  nx;
    logic seen;
    nx = cur;
    if (!rst_n) begin
      nx.hist   = '1;
      nx.run    = '0;
      nx.filt   = 1'b1;
      nx.rise   = 1'b0;
      nx.fall   = 1'b0;
      nx.sticky = 1'b0;
      return nx;
    end
    seen      = cur.hist[sy-1];
    nx.sticky = (cur.sticky & ~clear) | cur.rise | cur.fall;
    nx.rise   = 1'b0;
    nx.fall   = 1'b0;
    if (!ena || seen == cur.filt) begin
      nx.run = '0;
    end else if (int'(cur.run) + 1 >= fl) begin
      nx.filt = seen;
      nx.rise = seen;
      nx.fall = ~seen;
      nx.run  = '0;
    end else begin
      nx.run = cur.run + 8'd1;
    end
    nx.hist = {cur.hist[6:0], din};
    return nx;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m[0][c] <= model_step(m[0][c], SYNC_A, FL_A, n_rst, sig[c], en[c], clr[c]);
      m[1][c] <= model_step(m[1][c], SYNC_B, FL_B, n_rst, sig[c], en[c], clr[c]);
    end
  end

  wire [7:0] act_a = {bus_a.filt_out, bus_a.rising_edge, bus_a.falling_edge, bus_a.edge_sticky};
  wire [7:0] act_b = {bus_b.filt_out, bus_b.rising_edge, bus_b.falling_edge, bus_b.edge_sticky};
  wire [7:0] exp_a = {m[0][1].filt, m[0][0].filt, m[0][1].rise, m[0][0].rise,
                      m[0][1].fall, m[0][0].fall, m[0][1].sticky, m[0][0].sticky};
  wire [7:0] exp_b = {m[1][1].filt, m[1][0].filt, m[1][1].rise, m[1][0].rise,
                      m[1][1].fall, m[1][0].fall, m[1][1].sticky, m[1][0].sticky};

  // Returns 1ns after a rising edge: outputs of that edge are settled and
  // inputs driven now are seen by the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    sig   = 2'b00;
    en    = 2'b11;
    clr   = 2'b00;
    repeat (3) begin
      cyc();
      checks++;
      if ({bus_a.filt_out, bus_a.rising_edge, bus_a.falling_edge, bus_a.edge_sticky} !== 8'b11_00_00_00) begin
        errors++;
        $display("FAIL reset_state got=%b want=%b", act_a, 8'b11_00_00_00);
      end
    end
    cyc();
    n_rst = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      checks++;
      if ({bus_a.filt_out, bus_a.rising_edge, bus_a.falling_edge, bus_a.edge_sticky} !==
          {(e >= 6) ? 2'b00 : 2'b11, 2'b00, (e == 6) ? 2'b11 : 2'b00, (e >= 7) ? 2'b11 : 2'b00}) begin
        errors++;
        $display("FAIL reset_release edge=%0d got=%b", e, act_a);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL reset_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_glitch();
    sig = 2'b11;
    repeat (12) cyc();
    clr = 2'b11;
    cyc();
    clr = 2'b00;
    sig[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      checks++;
      if (bus_a.filt_out[0] !== 1'b1 || bus_a.falling_edge[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch3_reject edge=%0d filt=%b fall=%b want filt=1 fall=0",
                 e, bus_a.filt_out[0], bus_a.falling_edge[0]);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL glitch3_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
      if (e == 3) sig[0] = 1'b1;
    end
    sig[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      checks++;
      if (bus_a.falling_edge[0] !== (e == 6) || bus_a.rising_edge[0] !== (e == 10)) begin
        errors++;
        $display("FAIL glitch4_pass edge=%0d fall=%b rise=%b want fall=%b rise=%b",
                 e, bus_a.falling_edge[0], bus_a.rising_edge[0], e == 6, e == 10);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL glitch4_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
      if (e == 4) sig[0] = 1'b1;
    end
  endtask

  task automatic test_rising_indep();
    sig[1] = 1'b0;
    repeat (12) cyc();
    sig[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      checks++;
      if (bus_a.rising_edge[1] !== (e == 6) ||
          {bus_a.filt_out[0], bus_a.rising_edge[0], bus_a.falling_edge[0]} !== 3'b100) begin
        errors++;
        $display("FAIL rise_indep edge=%0d rise1=%b ch0=%b want rise1=%b ch0=100", e,
                 bus_a.rising_edge[1], {bus_a.filt_out[0], bus_a.rising_edge[0], bus_a.falling_edge[0]}, e == 6);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL rise_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_sticky();
    clr = 2'b01;
    cyc();
    clr = 2'b00;
    checks++;
    if (bus_a.edge_sticky[0] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_preclear got=%b want=0", bus_a.edge_sticky[0]);
    end
    sig[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      if (e == 6) begin
        checks++;
        if (bus_a.falling_edge[0] !== 1'b1) begin
          errors++;
          $display("FAIL sticky_edge got=%b want=1", bus_a.falling_edge[0]);
        end
        clr = 2'b01;
      end
      if (e == 7) begin
        checks++;
        if (bus_a.edge_sticky[0] !== 1'b1) begin
          errors++;
          $display("FAIL sticky_set_wins got=%b want=1", bus_a.edge_sticky[0]);
        end
        clr = 2'b00;
      end
    end
    repeat (3) cyc();
    checks++;
    if (bus_a.edge_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold got=%b want=1", bus_a.edge_sticky[0]);
    end
    clr = 2'b01;
    cyc();
    clr = 2'b00;
    checks++;
    if (bus_a.edge_sticky[0] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear got=%b want=0", bus_a.edge_sticky[0]);
    end
  endtask

  task automatic test_disable();
    sig = 2'b11;
    repeat (12) cyc();
    en = 2'b10;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) sig[0] = (i % 2 == 0);
      cyc();
      checks++;
      if ({bus_a.filt_out[0], bus_a.rising_edge[0], bus_a.falling_edge[0]} !== 3'b100) begin
        errors++;
        $display("FAIL disable_frozen cycle=%0d got=%b want=100", i,
                 {bus_a.filt_out[0], bus_a.rising_edge[0], bus_a.falling_edge[0]});
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL disable_model cycle=%0d got a=%b b=%b want a=%b b=%b", i, act_a, act_b, exp_a, exp_b);
      end
    end
    en = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      checks++;
      if (bus_a.falling_edge[0] !== (e == 4)) begin
        errors++;
        $display("FAIL reenable_qualify edge=%0d fall=%b want=%b", e, bus_a.falling_edge[0], e == 4);
      end
    end
  endtask

  task automatic test_midreset();
    sig = 2'b11;
    repeat (12) cyc();
    sig[0] = 1'b0;
    repeat (4) cyc();
    n_rst = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      cyc();
      checks++;
      if ({bus_a.filt_out, bus_a.rising_edge, bus_a.falling_edge, bus_a.edge_sticky} !== 8'b11_00_00_00) begin
        errors++;
        $display("FAIL midreset edge=%0d got=%b want=%b", e, act_a, 8'b11_00_00_00);
      end
    end
    n_rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL midreset_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_fl1();
    sig = 2'b11;
    repeat (12) cyc();
    sig[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      checks++;
      if (bus_b.falling_edge[0] !== (e == 4)) begin
        errors++;
        $display("FAIL fl1_latency edge=%0d fall=%b want=%b", e, bus_b.falling_edge[0], e == 4);
      end
    end
    sig[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      checks++;
      if (bus_b.falling_edge[1] !== (e == 4) || bus_b.rising_edge[1] !== (e == 5) ||
          bus_a.falling_edge[1] !== 1'b0) begin
        errors++;
        $display("FAIL fl1_pulse edge=%0d b_fall=%b b_rise=%b a_fall=%b want %b %b 0", e,
                 bus_b.falling_edge[1], bus_b.rising_edge[1], bus_a.falling_edge[1], e == 4, e == 5);
      end
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL fl1_model edge=%0d got a=%b b=%b want a=%b b=%b", e, act_a, act_b, exp_a, exp_b);
      end
      if (e == 1) sig[1] = 1'b1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc();
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL random_model cycle=%0d got a=%b b=%b want a=%b b=%b", i, act_a, act_b, exp_a, exp_b);
      end
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(4) == 0) sig[c] = ~sig[c];
        en[c]  = ($urandom_range(7) != 0);
        clr[c] = ($urandom_range(7) == 0);
      end
      n_rst = ($urandom_range(99) != 0);
    end
    n_rst = 1'b1;
    en    = 2'b11;
    clr   = 2'b00;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL random_tail cycle=%0d got a=%b b=%b want a=%b b=%b", i, act_a, act_b, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rising_indep();
    test_sticky();
    test_disable();
    test_midreset();
    test_fl1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
